cov_update_sequencer: RTL

- Initiator side of the update_cov interface. Owns the running covariance state: moment matrix, mean vector, sample count T and previous price vector.
- Accepts a stream of 4-asset Q8.8 price vectors and issues one update_cov transaction per new price.
- Captures new_moment, new_mean and new_cov, then writes the moment and mean back as state for the next update.
- Sits between the price-ingest front end and update_cov, and presents the latest covariance matrix to downstream strategy logic.

---
 rtl/cov_update_sequencer_if.sv | 22 ++
 rtl/cov_update_sequencer.sv | 99 +++++++++
 2 files changed

// File: rtl/cov_update_sequencer_if.sv
// cov_update_sequencer_if: request/response bundle between the sequencer and update_cov
interface cov_update_sequencer_if #(parameter int WIDTH = 16, parameter int N = 4);
  logic signed [WIDTH-1:0] old_p [0:N-1];
  logic signed [WIDTH-1:0] new_p [0:N-1];
  logic signed [WIDTH-1:0] old_moment [0:N-1][0:N-1];
  logic signed [WIDTH-1:0] old_mean [0:N-1];
  logic [WIDTH-1:0] T;
  logic valid;
  logic signed [WIDTH-1:0] new_moment [0:N-1][0:N-1];
  logic signed [WIDTH-1:0] new_cov [0:N-1][0:N-1];
  logic signed [WIDTH-1:0] new_mean [0:N-1];
  logic ready;
  logic overflow;
  modport master (
    output old_p, new_p, old_moment, old_mean, T, valid,
    input new_moment, new_cov, new_mean, ready, overflow
  );
  modport slave (
    input old_p, new_p, old_moment, old_mean, T, valid,
    output new_moment, new_cov, new_mean, ready, overflow
  );
endinterface

// File: rtl/cov_update_sequencer.sv
// cov_update_sequencer: owns running covariance state and issues one update_cov request per new price
module cov_update_sequencer #(
  parameter int WIDTH = 16,
  parameter int N = 4,
  parameter int T_MAX = 1024
) (
  input  logic clk_100mhz,
  input  logic reset,
  input  logic signed [WIDTH-1:0] price [0:N-1],
  input  logic price_valid,
  output logic price_ready,
  input  logic flush,
  input  logic clear_overflow,
  cov_update_sequencer_if.master uc,
  output logic signed [WIDTH-1:0] cov_out [0:N-1][0:N-1],
  output logic cov_valid,
  output logic overflow_flag
);
  localparam int CW = $clog2(T_MAX + 1);
  typedef enum logic [1:0] {EMPTY, PRIMED, ISSUE, WAIT} state_t;
  state_t state;
  logic signed [WIDTH-1:0] moment [0:N-1][0:N-1];
  logic signed [WIDTH-1:0] mean [0:N-1];
  logic signed [WIDTH-1:0] prev_p [0:N-1];
  logic [CW-1:0] count;
  logic accept;
  logic result;
  assign accept = price_valid && price_ready;
  assign result = state == WAIT && uc.ready;
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      price_ready <= 1'b1;
      uc.valid <= 1'b0;
      cov_valid <= 1'b0;
      moment <= '{default: '0};
      mean <= '{default: '0};
      prev_p <= '{default: '0};
      count <= '0;
      uc.old_p <= '{default: '0};
      uc.new_p <= '{default: '0};
      uc.old_moment <= '{default: '0};
      uc.old_mean <= '{default: '0};
      uc.T <= '0;
      cov_out <= '{default: '0};
    end else if (flush) begin
      state <= EMPTY;
      price_ready <= 1'b1;
      uc.valid <= 1'b0;
      cov_valid <= 1'b0;
      moment <= '{default: '0};
      mean <= '{default: '0};
      prev_p <= '{default: '0};
      count <= '0;
      cov_out <= '{default: '0};
    end else begin
      cov_valid <= 1'b0;
      case (state)
        EMPTY: if (accept) begin
          prev_p <= price;
          state <= PRIMED;
        end
        PRIMED: if (accept) begin
          uc.old_p <= prev_p;
          uc.new_p <= price;
          uc.old_moment <= moment;
          uc.old_mean <= mean;
          uc.T <= WIDTH'(count);
          uc.valid <= 1'b1;
          price_ready <= 1'b0;
          state <= ISSUE;
        end
        ISSUE: begin
          uc.valid <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (uc.ready) begin
          // an overflowed result is dropped, but the price still becomes the new reference
          if (!uc.overflow) begin
            moment <= uc.new_moment;
            mean <= uc.new_mean;
            cov_out <= uc.new_cov;
            count <= count < CW'(T_MAX) ? count + 1'b1 : count;
            cov_valid <= 1'b1;
          end
          prev_p <= uc.new_p;
          price_ready <= 1'b1;
          state <= PRIMED;
        end
      endcase
    end
  end
  // a fresh overflow beats a simultaneous clear; a flushed result cannot raise it
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) overflow_flag <= 1'b0;
    else if (result && uc.overflow && !flush) overflow_flag <= 1'b1;
    else if (clear_overflow) overflow_flag <= 1'b0;
  end
endmodule
